// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcode constants, datapath defaults and the result tag that follows each grant.
package alu_share_arbiter_pkg;

    localparam int unsigned DefaultWordWidth = 32;
    localparam int unsigned MaxIdW           = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;

    typedef struct packed {
        logic              core;
        logic [MaxIdW-1:0] id;
    } res_tag_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo NumReq.
module alu_share_arbiter_rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic            found;
    logic [IdxW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            pos = IdxW'((32'(ptr_i) + i) % NumReq);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the core issue path (priority, with starvation guard) and
// NUM_REQ DC pointer auto-step requesters served round-robin; result and flags are registered.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = DefaultWordWidth,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    localparam int unsigned IdW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned StW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                core_valid,
    output logic                                core_ready,
    input  logic [3:0]                          core_opcode,
    input  logic [WORD_WIDTH-1:0]               core_a,
    input  logic [WORD_WIDTH-1:0]               core_b,
    input  logic                                core_ic,
    input  logic                                core_store_carry,
    input  logic                                core_store_overflow,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]  req_ptr,
    input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]  req_stride,
    output logic [WORD_WIDTH-1:0]               alu_a,
    output logic [WORD_WIDTH-1:0]               alu_b,
    output logic                                alu_ic,
    output logic [3:0]                          alu_opcode,
    input  logic [WORD_WIDTH-1:0]               alu_out,
    input  logic                                alu_oc,
    input  logic                                alu_oflow,
    output logic                                res_valid,
    output logic                                res_core,
    output logic [IdW-1:0]                      res_id,
    output logic [WORD_WIDTH-1:0]               res_value,
    output logic                                carry,
    output logic                                overflow
);

    logic                  any_req, core_win, core_grant, dc_grant;
    logic [NUM_REQ-1:0]    rr_gnt;
    logic [IdW-1:0]        rr_idx, rr_q, rr_d;
    logic [StW-1:0]        starve_q, starve_d;
    res_tag_t              tag_q, tag_d;
    logic                  res_valid_q, carry_q, overflow_q;
    logic [WORD_WIDTH-1:0] res_value_q;
    logic                  unused_id_hi;

    alu_share_arbiter_rr_arbiter #(
        .NumReq (NUM_REQ),
        .IdxW   (IdW)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    // Core wins unless DC work is pending and the core has already had its quota.
    assign any_req    = |req_valid;
    assign core_win   = core_valid && (!any_req || (starve_q < StW'(STARVE_LIMIT)));
    assign core_grant = !reset && core_win;
    assign dc_grant   = !reset && !core_win && any_req;
    assign core_ready = core_grant;
    assign req_ready  = dc_grant ? rr_gnt : '0;

    always_comb begin
        alu_opcode = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        alu_ic     = 1'b0;
        if (core_grant) begin
            alu_opcode = core_opcode;
            alu_a      = core_a;
            alu_b      = core_b;
            alu_ic     = core_ic;
        end else if (dc_grant) begin
            alu_opcode = OP_ADD;
            alu_a      = req_stride[rr_idx];
            alu_b      = req_ptr[rr_idx];
        end
    end

    always_comb begin
        rr_d      = rr_q;
        starve_d  = starve_q;
        tag_d     = tag_q;
        tag_d.core = core_grant;
        tag_d.id   = core_grant ? '0 : MaxIdW'(rr_idx);
        if (dc_grant) begin
            rr_d     = (rr_idx == IdW'(NUM_REQ - 1)) ? '0 : rr_idx + IdW'(1);
            starve_d = '0;
        end else if (!any_req) begin
            starve_d = '0;
        end else if (core_grant && (starve_q < StW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            tag_q       <= '0;
            res_value_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            rr_q        <= '0;
            starve_q    <= '0;
        end else begin
            res_valid_q <= core_grant || dc_grant;
            if (core_grant || dc_grant) begin
                tag_q       <= tag_d;
                res_value_q <= alu_out;
            end
            // DC steps never touch the architectural flags.
            if (core_grant && core_store_carry) begin
                carry_q <= alu_oc;
            end
            if (core_grant && core_store_overflow) begin
                overflow_q <= alu_oflow;
            end
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_core     = tag_q.core;
    assign res_id       = tag_q.id[IdW-1:0];
    assign res_value    = res_value_q;
    assign carry        = carry_q;
    assign overflow     = overflow_q;
    assign unused_id_hi = ^tag_q.id;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the core's single ALU between the instruction-issue path and NUM_REQ DC auto-step requesters.
- Each DC requester adds a signed stride to a DC pointer.
- Core has priority, with a starvation guard.
- DC requesters are served round-robin.
- Registers the ALU result, the destination tag, and the architectural carry/overflow flags.
- Sits between the ALU control decode and the ALU; DC pointer writeback consumes the tagged results.

Parameters:
- WORD_WIDTH, 32, datapath width.
- NUM_REQ, 4, number of DC requesters.
- STARVE_LIMIT, 3, consecutive core grants tolerated while any DC request is pending.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_valid  in  1  core operation offered.
- core_ready  out  1  core operation granted this cycle.
- core_opcode  in  4  ALU opcode (shared opcode constants).
- core_a  in  WORD_WIDTH  ALU A operand.
- core_b  in  WORD_WIDTH  ALU B operand (TOS).
- core_ic  in  1  incoming carry.
- core_store_carry  in  1  latch carry flag on completion.
- core_store_overflow  in  1  latch overflow flag on completion.
- req_valid  in  NUM_REQ  DC step requests.
- req_ready  out  NUM_REQ  one-hot grant.
- req_ptr  in  NUM_REQ x WORD_WIDTH  current DC pointer values.
- req_stride  in  NUM_REQ x WORD_WIDTH  signed strides.
- alu_a, alu_b  out  WORD_WIDTH  to ALU.
- alu_ic  out  1  to ALU.
- alu_opcode  out  4  to ALU.
- alu_out  in  WORD_WIDTH  ALU result (combinational, same cycle).
- alu_oc  in  1  ALU carry out.
- alu_oflow  in  1  ALU overflow out.
- res_valid  out  1  registered result valid.
- res_core  out  1  result belongs to core.
- res_id  out  log2(NUM_REQ)  DC index when res_core=0.
- res_value  out  WORD_WIDTH  registered result.
- carry  out  1  architectural carry flag.
- overflow  out  1  architectural overflow flag.

Behaviour:

Handshake rules:
- At most one grant per cycle.
- core_ready and req_ready are combinational from the valids and state.
- A requester holds valid and its operands stable until it sees ready.
- A transfer completes when valid && ready.

Grant selection:
- Core is granted when core_valid is set and either no req_valid bit is set or starve_cnt < STARVE_LIMIT.
- Otherwise the highest-priority pending DC requester is granted.
- DC priority is round-robin starting at rr_ptr; after a DC grant, rr_ptr = granted index + 1, modulo NUM_REQ.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each core grant while any req_valid bit is set;
  - clears on any DC grant;
  - clears when no req_valid bit is set.

ALU drive:
- Core grant: alu_* = core_* (alu_a=core_a, alu_b=core_b, alu_ic=core_ic, alu_opcode=core_opcode).
- DC grant: alu_a = req_stride[i], alu_b = req_ptr[i], alu_ic = 0, alu_opcode = OP_ADD.
- No grant: alu_opcode = OP_NOP, operands 0, alu_ic = 0.

Latency:
- Grant in cycle N produces res_valid=1 in cycle N+1, with res_value = alu_out sampled at N.
- res_core and res_id identify the winner.
- res_valid is 1 for exactly one cycle per grant.

Flags:
- At N+1, carry <= alu_oc if the winner was core and core_store_carry=1.
- At N+1, overflow <= alu_oflow if the winner was core and core_store_overflow=1.
- DC grants never touch the flags.
- Wrap-around of pointer arithmetic is modulo 2^WORD_WIDTH; alu_oc is ignored for DC grants.

Reset:
- res_valid=0, res_core=0, res_id=0, res_value=0, carry=0, overflow=0, rr_ptr=0, starve_cnt=0.
- While reset is high: all readies 0 and alu_opcode = OP_NOP.
- A grant in the cycle reset asserts produces no result.

Boundary and corner cases:
- No valids: idle, no state change except starve_cnt clears.
- All NUM_REQ valid: strict rotation 0,1,2,3,0…
- NUM_REQ valid bits only, no core: back-to-back DC grants every cycle.

Decomposition:
- Shared package: OP_* opcode constants (existing), the WORD_WIDTH default, and a res_tag struct {core, id}.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin picker). Inputs: request vector and rr_ptr. Outputs: one-hot grant and encoded index.
- Everything else is inline.

Test Plan:
- Reset, then core_valid=1, opcode=OP_ADD, a=0xFFFFFFFF, b=1, store_carry=1 → core_ready=1 at N; at N+1 res_valid=1, res_core=1, res_value=0, carry=1.
- req_valid=4'b1111, no core for 5 cycles → grants 0,1,2,3,0; each res_value = ptr+stride; flags unchanged.
- core_valid held high with req_valid[2]=1, STARVE_LIMIT=3 → grants core, core, core, DC2, core.
- DC1 with ptr=0xFFFFFFFC, stride=8 → res_value=4, res_id=1, carry unchanged.
- Core ADD with store_carry=0 and store_overflow=0, producing a carry → carry and overflow keep their prior values.
- Assert reset in the same cycle as a core grant → no res_valid next cycle; flags=0, rr_ptr=0.
